fact_ctrl_unit: RTL and testbench
=================================

Name: fact_ctrl_unit

Overview:
Moore-style control FSM for the factorial accelerator datapath (down-counter, product register, comparator, output buffer). On `go` it loads n into the counter and 1 into the product register. It then repeatedly multiplies and decrements while the comparator reports count > 1, and finally enables the result buffer and asserts `done`. The current state code is exported on `cs` for debug.

Parameters:
None. State encoding is fixed at 3 bits.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
go  input  1  start request, level-sensitive, sampled in IDLE
greater  input  1  datapath comparator: counter value > 1
CNTLD  output  1  counter parallel load (loads n)
UD  output  1  counter direction, 1 = up, 0 = down; always 0 in this design
CE  output  1  counter enable
CNTRST  output  1  counter synchronous clear
BUFEN  output  1  output tri-state/buffer enable
MUXSEL1  output  1  product-register input select: 0 = constant 1, 1 = multiplier product
MUXSEL2  output  1  result mux: 0 = zero, 1 = product register
REGLD  output  1  product register load
done  output  1  computation complete
cs  output  3  current state code

Behaviour:
- One clock domain. Reset is asynchronous and active-high.
- `rst` forces `cs` = IDLE (3'd0) immediately, independent of `clk`; it takes effect even mid-computation.
- All control outputs are combinational decodes of `cs` only (Moore); there is no input-to-output combinational path.
- Each state's outputs are listed below; any output not listed is 0.
- IDLE (0): CNTRST=1. Next state is INIT if go=1, else IDLE.
- INIT (1): CNTLD=1, CE=1, MUXSEL1=0, REGLD=1. Next state is always CHECK.
- CHECK (2): no outputs asserted. Next state is MULT if greater=1, else DONE.
- MULT (3): CE=1, UD=0, MUXSEL1=1, REGLD=1. Next state is always CHECK. Each multiply and decrement therefore takes 2 cycles (MULT then CHECK).
- DONE (4): done=1, BUFEN=1, MUXSEL2=1. Next state without the optional feature is IDLE (done is a 1-cycle pulse).
- Reset values, i.e. the IDLE decode: CNTRST=1, every other output 0, cs=0.
- Codes 5..7 are illegal. Their decode drives every output to 0, and their next state is IDLE.
- Latency from go sampled high to done: 1 (INIT) + 1 (CHECK) + 2 per MULT iteration + 1 (entry into DONE).
  - n ≤ 1: done asserts 3 cycles after the go edge.
  - k MULT iterations: 3 + 2k cycles.
- If go is held high, a new computation restarts automatically from IDLE after DONE.
- go is ignored in every state except IDLE.
- greater is ignored in every state except CHECK.

Optional Feature:
FACT_DONE_HOLD_EN
- Defined: DONE is sticky. It stays in DONE (done=1, BUFEN=1, MUXSEL2=1) while go=1, and moves to IDLE on the first clock edge with go=0. This gives the host a level-style handshake.
- Not defined: DONE always returns to IDLE after exactly one cycle, as specified in Behaviour.

Test Plan:
- Reset: with go=0, pulse rst high for 5 ns mid-cycle. Expect cs=0 immediately (asynchronous), CNTRST=1, and all other outputs 0.
- Short run: go=1, greater=0. Expect cs sequence 0,1,2,4 on successive edges. INIT shows CNTLD=CE=REGLD=1 and MUXSEL1=0. DONE shows done=BUFEN=MUXSEL2=1. Then cs=0 (feature off).
- Loop: go=1, greater=1 for 16 clocks then 0. Expect cs alternating 2,3,2,3... In MULT: CE=REGLD=MUXSEL1=1 and UD=0. After greater falls, the next CHECK goes to 4.
- Auto-restart: go held at 1 continuously. Expect the 0→1→2→... sequence to repeat after every DONE (feature off). With FACT_DONE_HOLD_EN, cs stays at 4 until go=0, then goes to 0.
- Mid-run reset: assert rst while cs=3. Expect cs=0 at once, outputs as IDLE, and no further REGLD pulses.
- Illegal state: force cs to 6. Expect all outputs 0 and cs=0 after the next edge.

Source files
------------

// File: rtl/fact_ctrl_unit.sv
// Moore control FSM for the factorial datapath: load, multiply/decrement loop, done.
// Build option: define FACT_DONE_HOLD_EN to hold DONE while go stays high.
module fact_ctrl_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  logic       greater,
  output logic       CNTLD,
  output logic       UD,
  output logic       CE,
  output logic       CNTRST,
  output logic       BUFEN,
  output logic       MUXSEL1,
  output logic       MUXSEL2,
  output logic       REGLD,
  output logic       done,
  output logic [2:0] cs
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    CHECK = 3'd2,
    MULT  = 3'd3,
    DONE  = 3'd4
  } state_t;

  logic [2:0] cs_q;
  logic [2:0] ns;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cs_q <= IDLE;
    else     cs_q <= ns;
  end

  always_comb begin
    ns = IDLE;
    unique case (cs_q)
      IDLE:  ns = go ? INIT : IDLE;
      INIT:  ns = CHECK;
      CHECK: ns = greater ? MULT : DONE;
      MULT:  ns = CHECK;
`ifdef FACT_DONE_HOLD_EN
      DONE:  ns = go ? DONE : IDLE;
`else
      DONE:  ns = IDLE;
`endif
      default: ns = IDLE;
    endcase
  end

  // Outputs depend on the state code only; codes 5..7 decode to all zeros.
  always_comb begin
    CNTLD   = 1'b0;
    CE      = 1'b0;
    CNTRST  = 1'b0;
    BUFEN   = 1'b0;
    MUXSEL1 = 1'b0;
    MUXSEL2 = 1'b0;
    REGLD   = 1'b0;
    done    = 1'b0;
    unique case (cs_q)
      IDLE: CNTRST = 1'b1;
      INIT: begin
        CNTLD = 1'b1;
        CE    = 1'b1;
        REGLD = 1'b1;
      end
      CHECK: ;
      MULT: begin
        CE      = 1'b1;
        MUXSEL1 = 1'b1;
        REGLD   = 1'b1;
      end
      DONE: begin
        done    = 1'b1;
        BUFEN   = 1'b1;
        MUXSEL2 = 1'b1;
      end
      default: ;
    endcase
  end

  assign UD = 1'b0;
  assign cs = cs_q;

endmodule

// File: tb/tb_fact_ctrl_unit.sv
// Randomized bench for fact_ctrl_unit against a behavioural model.
// Honors FACT_DONE_HOLD_EN the same way the design does.
module tb_fact_ctrl_unit;

  logic clk = 1'b0;
  logic rst, go, greater;
  logic CNTLD, UD, CE, CNTRST, BUFEN;
  logic MUXSEL1, MUXSEL2, REGLD, done;
  logic [2:0] cs;

  int checks = 0;
  int errors = 0;

  int m_cs;
  int cyc = 0;
  int t_start = 0;
  int iters = 0;

  fact_ctrl_unit dut (
    .clk(clk), .rst(rst), .go(go), .greater(greater),
    .CNTLD(CNTLD), .UD(UD), .CE(CE), .CNTRST(CNTRST),
    .BUFEN(BUFEN), .MUXSEL1(MUXSEL1), .MUXSEL2(MUXSEL2),
    .REGLD(REGLD), .done(done), .cs(cs)
  );

  always #5 clk = ~clk;

  wire [8:0] outs = {CNTLD, UD, CE, CNTRST, BUFEN,
                     MUXSEL1, MUXSEL2, REGLD, done};

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // {CNTLD,UD,CE,CNTRST,BUFEN,MUXSEL1,MUXSEL2,REGLD,done} per phase
  function automatic logic [8:0] ref_outs(input int s);
    case (s)
      0:       return 9'b000100000;
      1:       return 9'b101000010;
      3:       return 9'b001001010;
      4:       return 9'b000010101;
      default: return 9'b000000000;
    endcase
  endfunction

  function automatic int ref_next(input int s, input logic g,
                                  input logic gr);
    case (s)
      0: return g ? 1 : 0;
      1: return 2;
      2: return gr ? 3 : 4;
      3: return 2;
`ifdef FACT_DONE_HOLD_EN
      4: return g ? 4 : 0;
`else
      4: return 0;
`endif
      default: return 0;
    endcase
  endfunction

  task automatic check_now(input string tag);
    chk({tag, "_cs"}, cs, m_cs);
    chk({tag, "_out"}, outs, ref_outs(m_cs));
  endtask

  // one clock: apply inputs, advance model at the edge, check after it
  task automatic cycle(input logic g, input logic gr);
    int nxt;
    go = g;
    greater = gr;
    @(posedge clk);
    cyc++;
    nxt = ref_next(m_cs, g, gr);
    if (m_cs == 0 && g) begin
      t_start = cyc;
      iters = 0;
    end
    if (nxt == 3) iters++;
    #1;
    if (nxt == 4 && m_cs != 4) begin
      m_cs = nxt;
      chk("latency", cyc - t_start + 1, 3 + 2 * iters);
    end
    m_cs = nxt;
    check_now("cyc");
  endtask

  // 5 ns asynchronous pulse between edges; called at posedge+1
  task automatic rst_pulse();
    #1 rst = 1'b1;
    #1;
    m_cs = 0;
    check_now("arst");
    #4 rst = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1;
    go = 1'b0;
    greater = 1'b0;
    m_cs = 0;
    #12 rst = 1'b0;
    check_now("reset");

    // short run: n <= 1
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0);

    // long loop: greater high for 16 clocks
    cycle(1'b1, 1'b1);
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0);

    // auto-restart / hold with go stuck high
    for (int i = 0; i < 30; i++) cycle(1'b1, ($urandom_range(0, 2) == 0));
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0);

    // reset in the middle of MULT
    n = 0;
    cycle(1'b1, 1'b1);
    while (m_cs != 3 && n < 40) begin
      cycle(1'b0, 1'b1);
      n++;
    end
    chk("reach_mult", m_cs, 3);
    rst_pulse();
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1);

    // random traffic with occasional async resets
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0));
      if ($urandom_range(0, 60) == 0) rst_pulse();
    end
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0);

    // illegal code 6 decodes to zeros and recovers to IDLE
    force dut.cs_q = 3'd6;
    #1;
    chk("illegal_out", outs, 0);
    #2 release dut.cs_q;
    m_cs = 6;
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
